// File: rtl/conv1_event_scanner_pkg.sv
// conv1_event_scanner_pkg: shared constants and types for the conv-layer-1 event scanner.
//   - default image geometry (height, width, padding, kernel, guard gap) and padded row stride
//   - AER field widths
//   - scanner FSM state encoding
package conv1_event_scanner_pkg;

  localparam int unsigned CONV1_IMG_H = 28;
  localparam int unsigned CONV1_IMG_W = 28;
  localparam int unsigned CONV1_PAD   = 2;
  localparam int unsigned CONV1_K     = 5;
  localparam int unsigned CONV1_GAP   = 3;
  localparam int unsigned CONV1_W_PAD = CONV1_IMG_W + 2 * CONV1_PAD;

  localparam int unsigned AER_MN_W = 8;
  localparam int unsigned AER_CH_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain
  } scan_state_e;

endpackage

// File: rtl/conv1_event_scanner_if.sv
// conv1_event_scanner_if: AER input event handshake into the scanner.
//   aer_in_valid  event present
//   aer_in_M/N    event row/column, unpadded frame
//   aer_in_ready  scanner can take the event
//   master: event source; slave: scanner.
interface conv1_event_scanner_if;
  import conv1_event_scanner_pkg::*;

  logic                aer_in_valid;
  logic [AER_MN_W-1:0] aer_in_M;
  logic [AER_MN_W-1:0] aer_in_N;
  logic                aer_in_ready;

  modport master (output aer_in_valid, output aer_in_M, output aer_in_N, input aer_in_ready);
  modport slave  (input aer_in_valid, input aer_in_M, input aer_in_N, output aer_in_ready);

endinterface

// File: rtl/conv1_tap_counter.sv
// conv1_tap_counter: walks the K*K kernel taps of one event in raster order (i outer, j inner).
//   clk, rst_n     clock, asynchronous active-low reset
//   start          load tap 0 for event (ev_m, ev_n)
//   advance        step to the next tap
//   loc_m, loc_n   target neuron row/column of the current tap, padded frame
//   addr           loc_m*W_PAD + loc_n, tracked incrementally
//   weight         (K-1-i)*K + (K-1-j)
//   last           current tap is the final one (i == j == K-1)
module conv1_tap_counter
  import conv1_event_scanner_pkg::*;
#(
  parameter int unsigned K     = CONV1_K,
  parameter int unsigned W_PAD = CONV1_W_PAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        advance,
  input  logic [7:0]  ev_m,
  input  logic [7:0]  ev_n,
  output logic [7:0]  loc_m,
  output logic [7:0]  loc_n,
  output logic [15:0] addr,
  output logic [4:0]  weight,
  output logic        last
);

  localparam logic [4:0]  IdxMax = 5'(K - 1);
  localparam logic [15:0] Stride = 16'(W_PAD);

  logic [4:0]  i_q, i_d, j_q, j_d;
  logic [7:0]  n_base_q, n_base_d;
  logic [15:0] row_base_q, row_base_d;
  logic [7:0]  loc_m_q, loc_m_d, loc_n_q, loc_n_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0]  weight_q, weight_d;
  logic [15:0] row0;

  // Constant-stride multiply, only at event load; taps themselves use adds.
  assign row0 = 16'(ev_m) * Stride;

  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    n_base_d   = n_base_q;
    row_base_d = row_base_q;
    loc_m_d    = loc_m_q;
    loc_n_d    = loc_n_q;
    addr_d     = addr_q;
    weight_d   = weight_q;
    if (start) begin
      i_d        = '0;
      j_d        = '0;
      n_base_d   = ev_n;
      row_base_d = row0;
      loc_m_d    = ev_m;
      loc_n_d    = ev_n;
      addr_d     = row0 + {8'b0, ev_n};
      weight_d   = 5'(K * K - 1);
    end else if (advance) begin
      // Weight index runs K*K-1 down to 0 in raster order.
      weight_d = weight_q - 5'd1;
      if (j_q == IdxMax) begin
        j_d        = '0;
        i_d        = i_q + 5'd1;
        row_base_d = row_base_q + Stride;
        loc_m_d    = loc_m_q + 8'd1;
        loc_n_d    = n_base_q;
        addr_d     = row_base_q + Stride + {8'b0, n_base_q};
      end else begin
        j_d     = j_q + 5'd1;
        loc_n_d = loc_n_q + 8'd1;
        addr_d  = addr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q        <= '0;
      j_q        <= '0;
      n_base_q   <= '0;
      row_base_q <= '0;
      loc_m_q    <= '0;
      loc_n_q    <= '0;
      addr_q     <= '0;
      weight_q   <= '0;
    end else begin
      i_q        <= i_d;
      j_q        <= j_d;
      n_base_q   <= n_base_d;
      row_base_q <= row_base_d;
      loc_m_q    <= loc_m_d;
      loc_n_q    <= loc_n_d;
      addr_q     <= addr_d;
      weight_q   <= weight_d;
    end
  end

  assign loc_m  = loc_m_q;
  assign loc_n  = loc_n_q;
  assign addr   = addr_q;
  assign weight = weight_q;
  assign last   = (i_q == IdxMax) && (j_q == IdxMax);

endmodule

// File: rtl/conv1_event_scanner.sv
// conv1_event_scanner: expands one AER event into K*K conv-1 kernel taps, one per cycle,
// then holds off for GAP cycles so the core's read-modify-write cannot overlap events.
//   work_clk, rst_n      clock, asynchronous active-low reset
//   aer                  event handshake (slave side)
//   operating_flag       current tap valid for the core
//   Vmem_ram_address     target neuron address
//   Weight_rom_address   weight index of the tap
//   Location_M/N         target neuron row/column, padded frame
//   event_done           one-cycle pulse after an event's last tap
//   busy                 scanner not idle
// Optional: define CONV1_SKIP_PAD_TAPS_EN to drop operating_flag on taps landing in padding.
module conv1_event_scanner
  import conv1_event_scanner_pkg::*;
#(
  parameter int unsigned IMG_H = CONV1_IMG_H,
  parameter int unsigned IMG_W = CONV1_IMG_W,
  parameter int unsigned PAD   = CONV1_PAD,
  parameter int unsigned K     = CONV1_K,
  parameter int unsigned GAP   = CONV1_GAP
) (
  input  logic                  work_clk,
  input  logic                  rst_n,
  conv1_event_scanner_if.slave  aer,
  output logic                  operating_flag,
  output logic [15:0]           Vmem_ram_address,
  output logic [4:0]            Weight_rom_address,
  output logic [7:0]            Location_M,
  output logic [7:0]            Location_N,
  output logic                  event_done,
  output logic                  busy
);

  localparam int unsigned W_PAD = IMG_W + 2 * PAD;

  scan_state_e state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        issue_q, issue_d;
  logic        done_q, done_d;
  logic        start, advance, last, ready, in_range;

  assign in_range = (aer.aer_in_M < 8'(IMG_H)) && (aer.aer_in_N < 8'(IMG_W));

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    issue_d   = issue_q;
    done_d    = 1'b0;
    start     = 1'b0;
    advance   = 1'b0;
    ready     = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        // Out-of-range events still handshake but are dropped.
        if (aer.aer_in_valid && in_range) begin
          start   = 1'b1;
          issue_d = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (last) begin
          issue_d   = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = 4'(GAP);
          state_d   = (GAP == 0) ? StIdle : StDrain;
        end else begin
          advance = 1'b1;
        end
      end
      StDrain: begin
        if (gap_cnt_q <= 4'd1) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gap_cnt_q <= '0;
      issue_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      issue_q   <= issue_d;
      done_q    <= done_d;
    end
  end

  conv1_tap_counter #(
    .K     (K),
    .W_PAD (W_PAD)
  ) u_tap_counter (
    .clk     (work_clk),
    .rst_n   (rst_n),
    .start   (start),
    .advance (advance),
    .ev_m    (aer.aer_in_M),
    .ev_n    (aer.aer_in_N),
    .loc_m   (Location_M),
    .loc_n   (Location_N),
    .addr    (Vmem_ram_address),
    .weight  (Weight_rom_address),
    .last    (last)
  );

`ifdef CONV1_SKIP_PAD_TAPS_EN
  localparam logic [7:0] RowLo = 8'(PAD);
  localparam logic [7:0] RowHi = 8'(PAD + IMG_H);
  localparam logic [7:0] ColLo = 8'(PAD);
  localparam logic [7:0] ColHi = 8'(PAD + IMG_W);
  logic in_image;
  assign in_image = (Location_M >= RowLo) && (Location_M < RowHi) &&
                    (Location_N >= ColLo) && (Location_N < ColHi);
  // Tap still takes its cycle; only the write qualifier is suppressed.
  assign operating_flag = issue_q && in_image;
`else
  assign operating_flag = issue_q;
`endif

  assign event_done       = done_q;
  assign busy             = (state_q != StIdle);
  assign aer.aer_in_ready = ready;

endmodule
